// File: rtl/fcp_logical_layer_mv.sv
// FCP slave logical layer: command decode and queue, ping/respond sequencing,
// register file and stepped discrete output-voltage control.
module fcp_logical_layer_mv #(
    parameter int                      NUM_VOUT      = 3,
    parameter logic [8*NUM_VOUT-1:0]   VOUT_TABLE    = {8'd120, 8'd90, 8'd50},
    parameter int                      VOUT_STEP_CYC = 100,
    parameter int                      CMD_DEPTH     = 4,
    parameter logic [7:0]              MAX_PWR_VAL   = 8'h40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_VOUT-1:0] vout_enable_mask,
    input  logic                ping_from_master,
    input  logic                reset_from_master,
    input  logic                crc_error,
    input  logic                par_error,
    input  logic [23:0]         rx_data,
    input  logic                rx_data_valid,
    input  logic                tx_done,
    output logic                pl_tx_en,
    output logic                pl_tx_type,
    output logic [15:0]         pl_tx_data,
    output logic [2:0]          out_volt,
    output logic                volt_busy,
    output logic                cmd_overflow
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = (VOUT_STEP_CYC > 1) ? $clog2(VOUT_STEP_CYC) : 1;
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(CMD_DEPTH);
    localparam logic [CW-1:0] STEP_LAST = CW'(VOUT_STEP_CYC - 1);
    localparam logic [7:0]    ACK       = 8'h08;
    localparam logic [7:0]    NACK      = 8'h03;

    typedef enum logic [1:0] {CMD_INV = 2'd0, CMD_WR = 2'd1, CMD_RD = 2'd2} cmd_type_e;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND_PING = 2'd1, ST_SEND_RESP = 2'd2} state_e;

    typedef struct packed {
        cmd_type_e  typ;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    // Level-table entry for an index; out-of-range indices read as zero.
    function automatic logic [7:0] table_at(input logic [2:0] idx);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < NUM_VOUT; i++) begin
            if (idx == 3'(i)) v = VOUT_TABLE[8*i +: 8];
        end
        return v;
    endfunction

    // Enable-mask bit for an index; out-of-range indices read as disabled.
    function automatic logic mask_bit(input logic [NUM_VOUT-1:0] m, input logic [2:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NUM_VOUT; i++) begin
            if (idx == 3'(i)) b = m[i];
        end
        return b;
    endfunction

    // Index of the highest enabled level.
    function automatic logic [2:0] highest_idx(input logic [NUM_VOUT-1:0] m);
        logic [2:0] h;
        h = 3'd0;
        for (int i = 0; i < NUM_VOUT; i++) begin
            if (m[i]) h = 3'(i);
        end
        return h;
    endfunction

    state_e            state_q, state_d;
    cmd_t              mem_q [CMD_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              tx_en_q, tx_en_d;
    logic              tx_type_q, tx_type_d;
    logic [15:0]       tx_data_q, tx_data_d;
    logic              ovf_q;
    logic [2:0]        sstat_q, sstat_d;
    logic [7:0]        vout_config_q, vout_config_d;
    logic [2:0]        out_volt_q, out_volt_d;
    logic [2:0]        target_q, target_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;

    cmd_t              rx_cmd_s, head_s;
    logic              full_s, empty_s, push_req_s, push_s, ovf_s, pop_s;
    logic              rd_ok_s;
    logic [7:0]        rd_val_s;
    logic [15:0]       resp_s;
    logic              wr_cfg_s, set_vout_s, clr_sstat_s;
    logic              match_s;
    logic [2:0]        match_idx_s;

    assign pl_tx_en     = tx_en_q;
    assign pl_tx_type   = tx_type_q;
    assign pl_tx_data   = tx_data_q;
    assign out_volt     = out_volt_q;
    assign volt_busy    = busy_q;
    assign cmd_overflow = ovf_q;

    assign full_s     = (count_q == DEPTH_C);
    assign empty_s    = (count_q == '0);
    assign push_req_s = rx_data_valid && !reset_from_master;
    assign push_s     = push_req_s && !full_s;
    assign ovf_s      = push_req_s && full_s;
    assign head_s     = mem_q[rd_ptr_q];

    // Classify the received frame into write, read or invalid.
    always_comb begin
        rx_cmd_s = '{typ: CMD_INV, addr: 8'h00, data: 8'h00};
        if (rx_data[23:16] == 8'h0B) begin
            rx_cmd_s = '{typ: CMD_WR, addr: rx_data[15:8], data: rx_data[7:0]};
        end else if (rx_data[23:16] == 8'h00 && rx_data[15:8] == 8'h0C) begin
            rx_cmd_s = '{typ: CMD_RD, addr: rx_data[7:0], data: 8'h00};
        end else begin
            rx_cmd_s = '{typ: CMD_INV, addr: 8'h00, data: 8'h00};
        end
    end

    // Command FIFO; a master reset flushes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
        end else if (reset_from_master) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= rx_cmd_s;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Register-file read of the queue head's address, sampled at pop time.
    always_comb begin
        rd_ok_s  = 1'b1;
        rd_val_s = 8'h00;
        case (head_s.addr)
            8'h00: rd_val_s = 8'h01;
            8'h01: rd_val_s = 8'h20;
            8'h02: rd_val_s = 8'h00;
            8'h03: rd_val_s = {5'd0, sstat_q};
            8'h04: rd_val_s = 8'hBB;
            8'h20: rd_val_s = 8'h01;
            8'h21: rd_val_s = {5'd0, highest_idx(vout_enable_mask)};
            8'h22: rd_val_s = MAX_PWR_VAL;
            8'h28: rd_val_s = {7'd0, busy_q};
            8'h29: rd_val_s = table_at(out_volt_q);
            8'h2B: rd_val_s = 8'h00;
            8'h2C: rd_val_s = vout_config_q;
            default: begin
                if (head_s.addr[7:3] == 5'b00110 && int'(head_s.addr[2:0]) < NUM_VOUT
                    && mask_bit(vout_enable_mask, head_s.addr[2:0])) begin
                    rd_val_s = table_at(head_s.addr[2:0]);
                end else begin
                    rd_ok_s  = 1'b0;
                    rd_val_s = 8'h00;
                end
            end
        endcase
    end

    // Response word for the queue head.
    always_comb begin
        resp_s = {8'h00, NACK};
        case (head_s.typ)
            CMD_WR: begin
                if (head_s.addr == 8'h02 || head_s.addr == 8'h2B || head_s.addr == 8'h2C) begin
                    resp_s = {8'h00, ACK};
                end else begin
                    resp_s = {8'h00, NACK};
                end
            end
            CMD_RD: begin
                if (rd_ok_s) begin
                    resp_s = {ACK, rd_val_s};
                end else begin
                    resp_s = {NACK, 8'h00};
                end
            end
            default: resp_s = {8'h00, NACK};
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; master reset overrides everything.
    always_comb begin
        state_d = state_q;
        if (reset_from_master) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ping_from_master) state_d = ST_SEND_PING;
                    else                  state_d = ST_IDLE;
                end
                ST_SEND_PING: begin
                    if (tx_done && !empty_s)     state_d = ST_SEND_RESP;
                    else if (tx_done)            state_d = ST_IDLE;
                    else                         state_d = ST_SEND_PING;
                end
                ST_SEND_RESP: begin
                    if (tx_done) state_d = ST_IDLE;
                    else         state_d = ST_SEND_RESP;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: transmit requests and the pop/commit strobe.
    always_comb begin
        tx_en_d   = 1'b0;
        tx_type_d = tx_type_q;
        tx_data_d = tx_data_q;
        pop_s     = 1'b0;
        if (reset_from_master) begin
            tx_en_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ping_from_master) begin
                        tx_en_d   = 1'b1;
                        tx_type_d = 1'b0;
                    end else begin
                        tx_en_d = 1'b0;
                    end
                end
                ST_SEND_PING: begin
                    if (tx_done && !empty_s) begin
                        tx_en_d   = 1'b1;
                        tx_type_d = 1'b1;
                        tx_data_d = resp_s;
                        pop_s     = 1'b1;
                    end else begin
                        tx_en_d = 1'b0;
                    end
                end
                default: tx_en_d = 1'b0;
            endcase
        end
    end

    assign wr_cfg_s    = pop_s && head_s.typ == CMD_WR && head_s.addr == 8'h2C;
    assign set_vout_s  = pop_s && head_s.typ == CMD_WR && head_s.addr == 8'h2B && head_s.data[0];
    assign clr_sstat_s = pop_s && head_s.typ == CMD_RD && head_s.addr == 8'h03;

    // Lowest enabled level matching VOUT_CONFIG.
    always_comb begin
        match_s     = 1'b0;
        match_idx_s = 3'd0;
        for (int j = NUM_VOUT - 1; j >= 0; j--) begin
            if (VOUT_TABLE[8*j +: 8] == vout_config_q && vout_enable_mask[j]) begin
                match_s     = 1'b1;
                match_idx_s = 3'(j);
            end else begin
                match_s     = match_s;
                match_idx_s = match_idx_s;
            end
        end
    end

    // Status and config next state: error sets beat a read-clear.
    always_comb begin
        sstat_d       = clr_sstat_s ? 3'b000 : sstat_q;
        sstat_d       = sstat_d | {ovf_s, crc_error, par_error};
        vout_config_d = wr_cfg_s ? head_s.data : vout_config_q;
    end

    // Voltage ramp: one index per dwell period toward the target.
    always_comb begin
        target_d   = target_q;
        out_volt_d = out_volt_q;
        cnt_d      = '0;
        if (set_vout_s && match_s) begin
            target_d = match_idx_s;
        end else begin
            target_d = target_q;
        end
        if (out_volt_q != target_q) begin
            if (cnt_q == STEP_LAST) begin
                cnt_d      = '0;
                out_volt_d = (target_q > out_volt_q) ? out_volt_q + 3'd1 : out_volt_q - 3'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
        busy_d = (out_volt_d != target_d);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_en_q       <= 1'b0;
            tx_type_q     <= 1'b0;
            tx_data_q     <= 16'h0000;
            ovf_q         <= 1'b0;
            sstat_q       <= 3'b000;
            vout_config_q <= VOUT_TABLE[7:0];
            out_volt_q    <= 3'd0;
            target_q      <= 3'd0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
        end else begin
            tx_en_q       <= tx_en_d;
            tx_type_q     <= tx_type_d;
            tx_data_q     <= tx_data_d;
            ovf_q         <= ovf_s;
            sstat_q       <= sstat_d;
            vout_config_q <= vout_config_d;
            out_volt_q    <= out_volt_d;
            target_q      <= target_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
        end
    end

endmodule

// File: tb/tb_fcp_logical_layer_mv.sv
// Self-checking bench for fcp_logical_layer_mv: table of single-command
// transactions plus hand-written sequences for ramp, overflow and master reset.
module tb_fcp_logical_layer_mv;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  vout_enable_mask;
    logic        ping_from_master, reset_from_master, crc_error, par_error;
    logic [23:0] rx_data;
    logic        rx_data_valid, tx_done;
    logic        pl_tx_en, pl_tx_type, volt_busy, cmd_overflow;
    logic [15:0] pl_tx_data;
    logic [2:0]  out_volt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_tx_cyc = 0;

    typedef struct {
        logic        typ;
        logic        chk;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [23:0] cmd;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[19];

    fcp_logical_layer_mv dut (
        .clk               (clk),
        .rst               (rst),
        .vout_enable_mask  (vout_enable_mask),
        .ping_from_master  (ping_from_master),
        .reset_from_master (reset_from_master),
        .crc_error         (crc_error),
        .par_error         (par_error),
        .rx_data           (rx_data),
        .rx_data_valid     (rx_data_valid),
        .tx_done           (tx_done),
        .pl_tx_en          (pl_tx_en),
        .pl_tx_type        (pl_tx_type),
        .pl_tx_data        (pl_tx_data),
        .out_volt          (out_volt),
        .volt_busy         (volt_busy),
        .cmd_overflow      (cmd_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Push one frame; returns cmd_overflow sampled just after the push edge.
    task automatic push_cmd(input logic [23:0] d, output logic ovf);
        @(posedge clk); #1;
        rx_data = d; rx_data_valid = 1'b1;
        @(posedge clk); #1;
        rx_data_valid = 1'b0;
        ovf = cmd_overflow;
    endtask

    // Wait for a transmit request and compare it with the scoreboard head.
    task automatic wait_tx(input string name);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (pl_tx_en !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pl_tx_en !== 1'b1) begin
            errors++;
            $display("FAIL %s: pl_tx_en not seen within 40 cycles", name);
            if (sb.size() > 0) e = sb.pop_front();
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected pl_tx_en type %0d data %h", name, pl_tx_type, pl_tx_data);
        end else begin
            e = sb.pop_front();
            last_tx_cyc = cyc;
            if (pl_tx_type !== e.typ || (e.chk && pl_tx_data !== e.data)) begin
                errors++;
                $display("FAIL %s: got type %0d data %h expected type %0d data %h",
                         name, pl_tx_type, pl_tx_data, e.typ, e.data);
            end
        end
    endtask

    // Ping, expect PING; tx_done (optionally with par_error / master reset);
    // then either expect RESPOND with exp_data or expect silence.
    task automatic ping_cycle(input string name, input logic exp_resp, input logic [15:0] exp_data,
                              input logic par_at_done, input logic rfm_at_done);
        logic seen;
        sb.push_back('{typ: 1'b0, chk: 1'b0, data: 16'h0000});
        @(posedge clk); #1; ping_from_master = 1'b1;
        @(posedge clk); #1; ping_from_master = 1'b0;
        wait_tx({name, "_ping"});
        if (exp_resp) sb.push_back('{typ: 1'b1, chk: 1'b1, data: exp_data});
        @(posedge clk); #1;
        tx_done = 1'b1; par_error = par_at_done; reset_from_master = rfm_at_done;
        @(posedge clk); #1;
        tx_done = 1'b0; par_error = 1'b0; reset_from_master = 1'b0;
        if (exp_resp) begin
            wait_tx({name, "_resp"});
            @(posedge clk); #1; tx_done = 1'b1;
            @(posedge clk); #1; tx_done = 1'b0;
        end else begin
            seen = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (pl_tx_en === 1'b1) seen = 1'b1;
            end
            check({name, "_no_resp"}, {31'd0, seen}, 32'd0);
        end
    endtask

    task automatic txn(input string name, input logic [23:0] d, input logic [15:0] exp_data);
        logic ovf;
        push_cmd(d, ovf);
        ping_cycle(name, 1'b1, exp_data, 1'b0, 1'b0);
    endtask

    initial begin
        logic ovf;
        vecs[0]  = '{24'h0B2C5A, 16'h0008};
        vecs[1]  = '{24'h000C2C, 16'h085A};
        vecs[2]  = '{24'h000C00, 16'h0801};
        vecs[3]  = '{24'h000C01, 16'h0820};
        vecs[4]  = '{24'h000C04, 16'h08BB};
        vecs[5]  = '{24'h000C22, 16'h0840};
        vecs[6]  = '{24'h000C21, 16'h0802};
        vecs[7]  = '{24'h000C30, 16'h0832};
        vecs[8]  = '{24'h000C31, 16'h085A};
        vecs[9]  = '{24'h000C05, 16'h0300};
        vecs[10] = '{24'h0B0511, 16'h0003};
        vecs[11] = '{24'h550000, 16'h0003};
        vecs[12] = '{24'h000D00, 16'h0003};
        vecs[13] = '{24'h000C02, 16'h0800};
        vecs[14] = '{24'h0B0233, 16'h0008};
        vecs[15] = '{24'h000C29, 16'h0832};
        vecs[16] = '{24'h000C28, 16'h0800};
        vecs[17] = '{24'h000C03, 16'h0800};
        vecs[18] = '{24'h000C2B, 16'h0800};

        rst = 1'b1; vout_enable_mask = 3'b111;
        ping_from_master = 1'b0; reset_from_master = 1'b0; crc_error = 1'b0; par_error = 1'b0;
        rx_data = 24'h000000; rx_data_valid = 1'b0; tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {12'd0, pl_tx_en, pl_tx_type, out_volt, volt_busy, cmd_overflow, 13'd0},
              32'd0);
        check("rst_tx_data", {16'd0, pl_tx_data}, 32'd0);
        rst = 1'b0;

        // Single-command transactions.
        for (int i = 0; i < 19; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].exp);
        end

        // Unsupported level: no target change.
        vout_enable_mask = 3'b011;
        txn("cfg120", 24'h0B2C78, 16'h0008);
        txn("setv_nomatch", 24'h0B2B01, 16'h0008);
        repeat (120) @(posedge clk);
        #1;
        check("nomatch_volt", {28'd0, volt_busy, out_volt}, 32'd0);
        txn("rd32_masked", 24'h000C32, 16'h0300);
        txn("rd31_enabled", 24'h000C31, 16'h085A);

        // Ramp 0 -> 2 with the dwell timing.
        vout_enable_mask = 3'b111;
        txn("setv_ramp", 24'h0B2B01, 16'h0008);
        while (cyc < last_tx_cyc + 99) @(negedge clk);
        check("ramp_99", {28'd0, volt_busy, out_volt}, {28'd0, 1'b1, 3'd0});
        @(negedge clk);
        check("ramp_100", {28'd0, volt_busy, out_volt}, {28'd0, 1'b1, 3'd1});
        while (cyc < last_tx_cyc + 199) @(negedge clk);
        check("ramp_199", {28'd0, volt_busy, out_volt}, {28'd0, 1'b1, 3'd1});
        @(negedge clk);
        check("ramp_200", {28'd0, volt_busy, out_volt}, {28'd0, 1'b0, 3'd2});
        txn("vout_status", 24'h000C29, 16'h0878);
        txn("adapter_status", 24'h000C28, 16'h0800);

        // Queue overflow on the fifth push.
        for (int i = 0; i < 4; i++) begin
            push_cmd(24'h000C00, ovf);
            check($sformatf("no_ovf%0d", i), {31'd0, ovf}, 32'd0);
        end
        push_cmd(24'h000C00, ovf);
        check("ovf5", {31'd0, ovf}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            ping_cycle($sformatf("drain%0d", i), 1'b1, 16'h0801, 1'b0, 1'b0);
        end
        txn("sstat_ovf", 24'h000C03, 16'h0804);
        txn("sstat_cleared", 24'h000C03, 16'h0800);

        // Master reset flushes queued commands.
        push_cmd(24'h000C00, ovf);
        push_cmd(24'h000C01, ovf);
        @(posedge clk); #1; reset_from_master = 1'b1;
        @(posedge clk); #1; reset_from_master = 1'b0;
        ping_cycle("rfm_flush", 1'b0, 16'h0000, 1'b0, 1'b0);
        push_cmd(24'h000C00, ovf);
        ping_cycle("rfm_at_done", 1'b0, 16'h0000, 1'b0, 1'b1);
        ping_cycle("rfm_after", 1'b0, 16'h0000, 1'b0, 1'b0);

        // Error sets vs read-clear.
        @(posedge clk); #1; crc_error = 1'b1;
        @(posedge clk); #1; crc_error = 1'b0;
        push_cmd(24'h000C03, ovf);
        ping_cycle("clr_vs_par", 1'b1, 16'h0802, 1'b1, 1'b0);
        txn("par_kept", 24'h000C03, 16'h0801);
        txn("par_cleared", 24'h000C03, 16'h0800);

        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fcp_logical_layer_mv.md
Name: fcp_logical_layer_mv

Overview:
Parametrised next-generation FCP slave logical layer. It sits between the FCP physical/packet layer and the adapter power stage.
- Decodes SBRWR/SBRRD commands into a register file and answers master pings with PING/RESPOND requests.
- Buffers up to CMD_DEPTH received commands in a queue.
- Supports NUM_VOUT discrete output voltages, each enabled at run time.
- Ramps the output one table step at a time with a programmable dwell.

Parameters:
NUM_VOUT, 3, number of discrete voltage levels (2..8)
VOUT_TABLE, {8'd120,8'd90,8'd50}, flattened NUM_VOUT x 8-bit level table in 0.1 V units; entry i at bits [8i+7:8i]
VOUT_STEP_CYC, 100, clk cycles dwelt per single-index voltage step (>=1)
CMD_DEPTH, 4, command queue depth (power of 2, >=2)
MAX_PWR_VAL, 8'h40, value returned at MAX_PWR

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
vout_enable_mask  input  NUM_VOUT  bit i=1: level i supported; bit 0 must be tied 1
ping_from_master  input  1  master ping detected (1-cycle pulse)
reset_from_master  input  1  master reset detected (1-cycle pulse)
crc_error  input  1  CRC error on received frame (pulse)
par_error  input  1  parity error on received byte (pulse)
rx_data  input  24  received command {b2,b1,b0}
rx_data_valid  input  1  rx_data valid (1-cycle pulse)
tx_done  input  1  physical layer finished current transmission (pulse)
pl_tx_en  output  1  transmit request (1-cycle pulse)
pl_tx_type  output  1  0=PING, 1=RESPOND; valid with pl_tx_en
pl_tx_data  output  16  response word; valid with pl_tx_en, held until next load
out_volt  output  3  current level index into VOUT_TABLE
volt_busy  output  1  high while out_volt != target index
cmd_overflow  output  1  1-cycle pulse: command dropped, queue full

Behaviour:
- One clock domain. Reset is synchronous and active-high (rst sampled on posedge clk). All registers reset on rst.
- Reset values:
  - pl_tx_en=0, pl_tx_type=0, pl_tx_data=0, out_volt=0, volt_busy=0, cmd_overflow=0.
  - Queue empty, FSM IDLE, SSTAT=0, VOUT_CONFIG=VOUT_TABLE[0].
- Decode on rx_data_valid:
  - WR when b2==8'h0B: addr=b1, data=b0.
  - RD when b2==8'h00 && b1==8'h0C: addr=b0.
  - Otherwise INVALID.
  - The entry {type,addr,data} is pushed the same cycle.
- Queue full on push:
  - Entry dropped, cmd_overflow pulses, SSTAT[2] set.
- FSM states:
  - IDLE: ping_from_master -> SEND_PING. The next cycle registers pl_tx_en=1, pl_tx_type=0.
  - SEND_PING, tx_done, queue non-empty -> SEND_RESP. The next cycle registers pl_tx_en=1, pl_tx_type=1, pl_tx_data=resp(head). The same edge pops the head and commits its write/read side-effects.
  - SEND_PING, tx_done, queue empty -> IDLE.
  - SEND_RESP, tx_done -> IDLE. One response is sent per ping.
  - reset_from_master in any state -> IDLE. The queue is flushed, no commit happens, and any pl_tx_en for that cycle is suppressed. This has priority over ping/tx_done/push in the same cycle.
- Response word (ACK=8'h08, NACK=8'h03):
  - WR: {8'h00, ACK if addr in {02,2B,2C} else NACK}.
  - RD: {ACK, regdata} if addr is readable, else {NACK, 8'h00}.
  - INVALID: {8'h00, NACK}.
  - Register values are sampled at pop time, so an earlier queued write is visible to a later read.
- Register map (R=read, RW, RC=read-clear):
  - 00 DVCTYPE 01 R; 01 SPEC_VER 20 R; 02 SCNTL RW, always reads 00.
  - 03 SSTAT RC: bit0 parity, bit1 crc, bit2 overflow.
  - 04 ID_OUI0 BB R.
  - 20 CAPABILITIES 01 R.
  - 21 DISCRETE_CAPABILITIES R = index of highest set bit of vout_enable_mask.
  - 22 MAX_PWR = MAX_PWR_VAL R.
  - 28 ADAPTER_STATUS R: bit0 = volt_busy.
  - 29 VOUT_STATUS R = VOUT_TABLE[out_volt].
  - 2B OUTPUT_CONTROL: write bit0=SET_VOUT, self-clearing, reads 00.
  - 2C VOUT_CONFIG RW.
  - 30+i DISCRETE_VOUT_i R = VOUT_TABLE[i]; exists only if i<NUM_VOUT && vout_enable_mask[i].
  - All other addresses are non-existent.
- SSTAT:
  - Error pulses set their bit.
  - A committed read of 03 clears all bits, and returns the pre-clear value.
  - A set arriving in the same cycle as the clear wins.
- Voltage control:
  - A committed SET_VOUT looks up the lowest index j with VOUT_TABLE[j]==VOUT_CONFIG && mask[j], and sets target=j.
  - No match: ignored, target unchanged.
  - When target!=out_volt, a dwell counter runs. Every VOUT_STEP_CYC cycles, out_volt moves ±1 toward target.
  - The first step occurs VOUT_STEP_CYC cycles after the commit.
  - Retargeting mid-ramp keeps the counter running. The counter clears when out_volt==target.
  - reset_from_master does not change out_volt or target.

Test Plan:
- Write 0B_2C_5A, ping, tx_done -> PING pulse, then RESPOND with pl_tx_data=0x0008; a subsequent read of 2C returns 0x085A.
- With mask=3'b011: VOUT_CONFIG=120 then SET_VOUT -> NACK-free ACK, target unchanged, out_volt=0. Read 32 -> 0x0300.
- VOUT_CONFIG=120, mask=3'b111, SET_VOUT -> volt_busy=1, out_volt=1 after 100 cycles, 2 after 200, then volt_busy=0, VOUT_STATUS=0x78.
- Push 5 commands with CMD_DEPTH=4 -> cmd_overflow pulse on the 5th; read 03 -> 0x0804, and a second read returns 0x0800.
- reset_from_master with 2 queued commands -> FSM IDLE, queue empty, no pl_tx_en; the next ping/tx_done yields PING only.
- Invalid command b2=0x55 -> RESPOND 0x0003. par_error and a read-of-03 commit in the same cycle -> SSTAT[0]=1 afterwards.
